// File: rtl/bin_to_bcd_seq_if.sv
// Connection between the adder/subtractor result, the BCD converter and the display driver.
// The master drives the result; the slave (the converter) returns the registered digits and status.
interface bin_to_bcd_seq_if;
  logic [8:0] value;
  logic       is_signed;
  logic       sign;
  logic [3:0] bcd_h;
  logic [3:0] bcd_t;
  logic [3:0] bcd_u;
  logic       ready;
  logic       done;
  logic       busy;

  modport master (
    output value, is_signed,
    input  sign, bcd_h, bcd_t, bcd_u, ready, done, busy
  );

  modport slave (
    input  value, is_signed,
    output sign, bcd_h, bcd_t, bcd_u, ready, done, busy
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: 9-bit result to sign plus three BCD digits.
// Digits are held in output registers and only change on the cycle done pulses.
//
// state   | meaning
// S_IDLE  | watching the input; capture on change or after reset
// S_SHIFT | nine add-3/shift steps on the scratch register
// S_DONE  | load digit/sign registers, pulse done next cycle
module bin_to_bcd_seq (
  input  logic            i_clk,
  input  logic            i_rst,
  bin_to_bcd_seq_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [8:0]  r_last_val;
  logic        r_last_sgn;
  logic        r_pending;
  logic        r_neg;
  logic [20:0] r_scratch;
  logic [3:0]  r_cnt;
  logic        r_sign;
  logic [3:0]  r_bcd_h;
  logic [3:0]  r_bcd_t;
  logic [3:0]  r_bcd_u;
  logic        r_ready;
  logic        r_done;

  logic        w_change;
  logic        w_neg;
  logic [8:0]  w_mag;
  logic [20:0] w_adj;

  assign w_change = r_pending | (bus.value != r_last_val) | (bus.is_signed != r_last_sgn);
  assign w_neg    = bus.is_signed & bus.value[8];
  // -256 negates to itself in 9 bits, which reads correctly as magnitude 256.
  assign w_mag    = w_neg ? (~bus.value + 9'd1) : bus.value;

  always_comb begin
    w_adj = r_scratch;
    if (r_scratch[12:9]  >= 4'd5) w_adj[12:9]  = r_scratch[12:9]  + 4'd3;
    if (r_scratch[16:13] >= 4'd5) w_adj[16:13] = r_scratch[16:13] + 4'd3;
    if (r_scratch[20:17] >= 4'd5) w_adj[20:17] = r_scratch[20:17] + 4'd3;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_change) w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == 4'd8) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_val <= 9'd0;
      r_last_sgn <= 1'b0;
      r_pending  <= 1'b1;
      r_neg      <= 1'b0;
      r_scratch  <= 21'd0;
      r_cnt      <= 4'd0;
      r_sign     <= 1'b0;
      r_bcd_h    <= 4'd0;
      r_bcd_t    <= 4'd0;
      r_bcd_u    <= 4'd0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_change) begin
            r_last_val <= bus.value;
            r_last_sgn <= bus.is_signed;
            r_pending  <= 1'b0;
            r_neg      <= w_neg;
            r_scratch  <= {12'd0, w_mag};
            r_cnt      <= 4'd0;
          end
        end
        S_SHIFT: begin
          r_scratch <= {w_adj[19:0], 1'b0};
          r_cnt     <= r_cnt + 4'd1;
        end
        S_DONE: begin
          r_bcd_h <= r_scratch[20:17];
          r_bcd_t <= r_scratch[16:13];
          r_bcd_u <= r_scratch[12:9];
          r_sign  <= r_neg;
          r_ready <= 1'b1;
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.sign  = r_sign;
  assign bus.bcd_h = r_bcd_h;
  assign bus.bcd_t = r_bcd_t;
  assign bus.bcd_u = r_bcd_u;
  assign bus.ready = r_ready;
  assign bus.done  = r_done;
  assign bus.busy  = (r_state != S_IDLE);
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: vector table plus hand sequences for startup,
// mid-conversion input change and reset abort.
module tb_bin_to_bcd_seq;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bin_to_bcd_seq_if bus();

  bin_to_bcd_seq dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] value;
    logic       sgn;
    logic       exp_sign;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] u;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns the number of falling edges until done is seen, or -1 on timeout.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got timeout expected done pulse");
    end
  endtask

  initial begin
    int n;
    int pulses;
    logic ok;
    logic [11:0] held;

    checks = 0;
    errors = 0;

    vecs[0] = '{9'd511,  1'b0, 1'b0, 4'd5, 4'd1, 4'd1};
    vecs[1] = '{9'd255,  1'b0, 1'b0, 4'd2, 4'd5, 4'd5};
    vecs[2] = '{9'h100,  1'b1, 1'b1, 4'd2, 4'd5, 4'd6};
    vecs[3] = '{9'h1FF,  1'b1, 1'b1, 4'd0, 4'd0, 4'd1};
    vecs[4] = '{9'd0,    1'b1, 1'b0, 4'd0, 4'd0, 4'd0};
    vecs[5] = '{9'h1F6,  1'b0, 1'b0, 4'd5, 4'd0, 4'd2};
    vecs[6] = '{9'h1F6,  1'b1, 1'b1, 4'd0, 4'd1, 4'd0};
    vecs[7] = '{9'h0FF,  1'b1, 1'b0, 4'd2, 4'd5, 4'd5};
    vecs[8] = '{9'h180,  1'b1, 1'b1, 4'd1, 4'd2, 4'd8};
    vecs[9] = '{9'h100,  1'b0, 1'b0, 4'd2, 4'd5, 4'd6};

    // Reset state
    rst = 1'b1;
    bus.value = 9'd0;
    bus.is_signed = 1'b0;
    #1;
    chk("rst_sign",   {31'd0, bus.sign}, 32'd0);
    chk("rst_digits", {20'd0, bus.bcd_h, bus.bcd_t, bus.bcd_u}, 32'd0);
    chk("rst_ready",  {31'd0, bus.ready}, 32'd0);
    chk("rst_done",   {31'd0, bus.done}, 32'd0);
    chk("rst_busy",   {31'd0, bus.busy}, 32'd0);

    // Startup conversion forced by pending
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    pulses = 0;
    n = -1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        pulses++;
        if (n < 0) n = i;
      end
      if (n < 0 && (bus.ready !== 1'b0 || {bus.bcd_h, bus.bcd_t, bus.bcd_u} !== 12'h000))
        ok = 1'b0;
    end
    chk("start_hold_before_done", {31'd0, ok}, 32'd1);
    chk("start_latency", n, 11);
    chk("start_pulses", pulses, 1);
    chk("start_sign",   {31'd0, bus.sign}, 32'd0);
    chk("start_digits", {20'd0, bus.bcd_h, bus.bcd_t, bus.bcd_u}, 32'd0);
    chk("start_ready",  {31'd0, bus.ready}, 32'd1);

    // Table of directed vectors
    for (int k = 0; k < 10; k++) begin
      bus.value = vecs[k].value;
      bus.is_signed = vecs[k].sgn;
      wait_done(n);
      chk($sformatf("vec%0d_latency", k), n, 11);
      chk($sformatf("vec%0d_sign", k), {31'd0, bus.sign}, {31'd0, vecs[k].exp_sign});
      chk($sformatf("vec%0d_digits", k), {20'd0, bus.bcd_h, bus.bcd_t, bus.bcd_u},
          {20'd0, vecs[k].h, vecs[k].t, vecs[k].u});
      chk($sformatf("vec%0d_ready", k), {31'd0, bus.ready}, 32'd1);
    end

    // Mode toggle with bits held: two conversions back to back
    bus.value = 9'h1F6;
    bus.is_signed = 1'b0;
    wait_done(n);
    chk("toggle_first", {19'd0, bus.sign, bus.bcd_h, bus.bcd_t, bus.bcd_u}, {19'd0, 1'b0, 12'h502});
    bus.is_signed = 1'b1;
    wait_done(n);
    chk("toggle_second", {19'd0, bus.sign, bus.bcd_h, bus.bcd_t, bus.bcd_u}, {19'd0, 1'b1, 12'h010});

    // Input changes while busy: second value converted after the first completes
    bus.value = 9'd123;
    bus.is_signed = 1'b0;
    @(negedge clk);
    chk("chg_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    bus.value = 9'd45;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("chg_first_seen", {31'd0, ok}, 32'd1);
    chk("chg_first", {20'd0, bus.bcd_h, bus.bcd_t, bus.bcd_u}, {20'd0, 12'h123});
    held = {bus.bcd_h, bus.bcd_t, bus.bcd_u};
    ok = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        pulses = 1;
        break;
      end
      if ({bus.bcd_h, bus.bcd_t, bus.bcd_u} !== held) ok = 1'b0;
    end
    chk("chg_hold_between", {31'd0, ok}, 32'd1);
    chk("chg_second_seen", pulses, 1);
    chk("chg_second", {20'd0, bus.bcd_h, bus.bcd_t, bus.bcd_u}, {20'd0, 12'h045});

    // Reset during SHIFT aborts and restarts with the current input
    bus.value = 9'd77;
    wait_done(n);
    chk("abort_pre", {20'd0, bus.bcd_h, bus.bcd_t, bus.bcd_u}, {20'd0, 12'h077});
    bus.value = 9'd300;
    repeat (4) @(negedge clk);
    chk("abort_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_digits", {20'd0, bus.bcd_h, bus.bcd_t, bus.bcd_u}, 32'd0);
    chk("abort_ready",  {31'd0, bus.ready}, 32'd0);
    chk("abort_idle",   {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        pulses++;
        if (n < 0) n = i;
      end
    end
    chk("abort_pulses",  pulses, 1);
    chk("abort_latency", n, 11);
    chk("abort_result",  {19'd0, bus.sign, bus.bcd_h, bus.bcd_t, bus.bcd_u}, {19'd0, 1'b0, 12'h300});
    chk("abort_ready_after", {31'd0, bus.ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter between the 9-bit adder/subtractor result and the multiplexed 7-segment display driver.
- Watches the 9-bit result continuously and re-runs a shift-and-add-3 (double-dabble) conversion whenever the value or its signedness changes.
- Presents a registered sign flag plus hundreds/tens/units BCD digits that stay stable between conversions, so the display never shows a half-converted value.

## Interface
Parameters: none (widths fixed by the 9-bit datapath).
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- value  input  9  result from the adder/subtractor, sampled only in IDLE
- is_signed  input  1  1 = treat value as 9-bit two's complement (subtract mode); 0 = unsigned
- sign  output  1  1 = displayed magnitude is negative
- bcd_h  output  4  hundreds digit, 0..5
- bcd_t  output  4  tens digit, 0..9
- bcd_u  output  4  units digit, 0..9
- ready  output  1  1 once at least one conversion has completed since reset; stays high
- done  output  1  one-cycle pulse when the digit outputs update
- busy  output  1  high while in SHIFT or DONE

## Operation
Internal registers:
- last_val[8:0], last_sgn: operands of the most recent capture.
- pending: forces a conversion after reset.
- neg: sign of the value being converted.
- scratch[20:0]: 12 BCD bits above 9 binary bits.
- cnt[3:0]: shift counter.

States are IDLE, SHIFT and DONE.
- **IDLE:** if pending = 1, or value != last_val, or is_signed != last_sgn:
  - load last_val/last_sgn from the inputs and clear pending;
  - neg = is_signed & value[8];
  - magnitude = neg ? (~value + 1) mod 512 : value. A signed -256 (9'h100) gives magnitude 256.
  - scratch = {12'b0, magnitude}, cnt = 0, go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT:** each cycle,
  - add 3 to every BCD nibble of scratch that is ≥ 5;
  - then shift scratch left by 1 and increment cnt;
  - after the 9th shift (cnt reaches 9) go to DONE.
- **DONE:**
  - bcd_h/t/u ← scratch[20:9] nibbles, sign ← neg;
  - ready ← 1, done = 1 for this cycle;
  - go to IDLE.
- Input changes during SHIFT/DONE are ignored. Because IDLE compares against last_val, the final settled input is always converted on return to IDLE, and intermediate values may be skipped.
- Sign rules:
  - sign is never 1 when is_signed = 0;
  - signed zero gives sign = 0.
- Digit limits: unsigned range 0..511, signed range -256..255. bcd_h never exceeds 5.

## Timing
- Reset values (asynchronous, take effect immediately):
  - outputs: sign = 0, bcd_h = bcd_t = bcd_u = 0, ready = 0, done = 0, busy = 0;
  - internal: state = IDLE, pending = 1, last_val = 0, last_sgn = 0.
- Capture edge E (IDLE, change detected): state = SHIFT and busy = 1 after E.
- Edges E+1..E+9 perform the 9 shift steps; state = DONE after E+9.
- Edge E+10 updates the digit registers and done is high for the cycle following E+10. busy drops with the return to IDLE.
- Latency from capture edge to new digits visible: 10 clocks. Earliest next capture: E+11.
- While busy, sign and the digits hold the previous result. Digits change only on a done edge.
- Reset asserted mid-conversion aborts it:
  - outputs return to reset values immediately;
  - after release, the first edge in IDLE captures the current input because pending = 1.
- No handshake with the display: the display reads the digits continuously.

## Test plan
- Reset, value = 0, is_signed = 0, release rst → ready = 0 and digits 000 until done. done pulses exactly once, 11 edges after release (pending capture on the first edge, digits at the 11th). Then sign = 0, digits 0,0,0, ready = 1.
- value = 9'd511, is_signed = 0 → after done: sign = 0, digits 5,1,1. Also value = 9'd255 → 2,5,5.
- is_signed = 1, value = 9'h100 → sign = 1, digits 2,5,6. value = 9'h1FF → sign = 1, digits 0,0,1. value = 9'd0 → sign = 0, digits 0,0,0.
- Same bits, mode toggle: value = 9'h1F6 held, is_signed toggled 0 → 1. Expect two done pulses: first 5,0,2 with sign = 0, then 0,1,0 with sign = 1.
- value = 123 captured, then changed to 45 three cycles later → first done shows 1,2,3, second done follows and shows 0,4,5. Digits are unchanged between the two done pulses.
- Converted value 77, then value changed to 300 and rst pulsed during SHIFT → digits 0,0,0 and ready = 0 immediately. After release, exactly one conversion runs and shows 3,0,0.
